active_sequencer: RTL and testbench

Wishbone-controlled scheduler for the shared user-project harness: it owns the one-hot `active` bus that gates each wrapped project's tristated outputs onto the shared IO pads. Switchover is break-before-make. All `active` lines drop, a programmable guard interval lets the pads settle, then exactly one project is enabled. The block sits in the harness between the Wishbone bus and the per-project `active` inputs.

---
 rtl/active_seq_pkg.sv | 40 ++++
 rtl/active_seq_wb_if.sv | 78 +++++++
 rtl/active_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_active_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/active_seq_pkg.sv
// rtl/active_seq_pkg.sv - shared constants, register map and state type for active_sequencer
package active_seq_pkg;

    localparam int IDX_W = 8;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    localparam int CTRL_EN_BIT   = 31;
    localparam int ST_CUR_EN_BIT = 8;
    localparam int ST_BUSY_BIT   = 9;
    localparam int ST_PEND_BIT   = 10;
    localparam int ST_ERR_BIT    = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_GUARD = 2'd2,
        S_APPLY = 2'd3
    } seq_state_e;

    // Assemble the STATUS register image from its individual fields
    function automatic logic [31:0] pack_status(
        input logic [IDX_W-1:0] cur_idx,
        input logic             cur_en,
        input logic             busy,
        input logic             pend,
        input logic             err
    );
        logic [31:0] s;
        s                = '0;
        s[IDX_W-1:0]     = cur_idx;
        s[ST_CUR_EN_BIT] = cur_en;
        s[ST_BUSY_BIT]   = busy;
        s[ST_PEND_BIT]   = pend;
        s[ST_ERR_BIT]    = err;
        return s;
    endfunction

endpackage

// File: rtl/active_seq_wb_if.sv
// rtl/active_seq_wb_if.sv - Wishbone slave: decode, single-cycle ack, registered read mux
module active_seq_wb_if
    import active_seq_pkg::*;
(
    input  logic             wb_clk_i,
    input  logic             rst_n,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      status_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             ctrl_wr_o,
    output logic [IDX_W-1:0] ctrl_idx_o,
    output logic             ctrl_en_o,
    output logic             err_clr_o
);

    logic             ack_q;
    logic [31:0]      dat_q;
    logic [IDX_W-1:0] last_idx_q;
    logic             last_en_q;
    logic             req;
    logic [1:0]       reg_sel;
    logic [31:0]      rdata;
    logic             unused_bits;

    // A request is taken only while ack is low, so acks can never be back to back
    assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign reg_sel = wbs_adr_i[3:2];

    // Partial-lane CTRL writes are acknowledged but never reach the sequencer
    assign ctrl_wr_o  = req & wbs_we_i & (reg_sel == REG_CTRL) & (wbs_sel_i == 4'hF);
    assign ctrl_idx_o = wbs_dat_i[IDX_W-1:0];
    assign ctrl_en_o  = wbs_dat_i[CTRL_EN_BIT];
    assign err_clr_o  = req & wbs_we_i & (reg_sel == REG_STATUS) & wbs_sel_i[1]
                      & wbs_dat_i[ST_ERR_BIT];

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // Address bits above [3:2] are qualified by the upstream decoder
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[30:12], wbs_dat_i[10:8]};

    // Read data selection for the addressed register
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[IDX_W-1:0]   = last_idx_q;
                rdata[CTRL_EN_BIT] = last_en_q;
            end
            REG_STATUS: rdata = status_i;
            default:    rdata = '0;
        endcase
    end

    // Ack, registered read data and the CTRL readback image
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            last_idx_q <= '0;
            last_en_q  <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= (req & ~wbs_we_i) ? rdata : '0;
            if (ctrl_wr_o) begin
                last_idx_q <= ctrl_idx_o;
                last_en_q  <= ctrl_en_o;
            end
        end
    end

endmodule

// File: rtl/active_sequencer.sv
// rtl/active_sequencer.sv - break-before-make scheduler for the one-hot project enable bus
module active_sequencer
    import active_seq_pkg::*;
#(
    parameter int NUM_PROJ     = 16,
    parameter int GUARD_CYCLES = 8
) (
    input  logic                wb_clk_i,
    input  logic                rst_n,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic [NUM_PROJ-1:0] active_o,
    output logic                busy_o,
    output logic                irq_o
);

    localparam int                  CNT_W        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W:0]      NUM_PROJ_LIM = (IDX_W + 1)'(NUM_PROJ);
    localparam logic [NUM_PROJ-1:0] PROJ_ONE     = NUM_PROJ'(1);

    seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    tgt_idx_q, tgt_idx_d;
    logic                tgt_en_q, tgt_en_d;
    logic                pend_q, pend_d;
    logic [IDX_W-1:0]    pend_idx_q, pend_idx_d;
    logic                pend_en_q, pend_en_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic                cur_en_q, cur_en_d;
    logic [NUM_PROJ-1:0] active_q, active_d;
    logic                err_q;

    logic                ctrl_wr;
    logic [IDX_W-1:0]    ctrl_idx;
    logic                ctrl_en;
    logic                err_clr;
    logic                req_bad;
    logic                req_ok;
    logic                cand_v;
    logic [IDX_W-1:0]    cand_idx;
    logic                cand_en;
    logic                cand_new;
    logic [31:0]         status_vec;

    active_seq_wb_if u_wb_if (
        .wb_clk_i   (wb_clk_i),
        .rst_n      (rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .status_i   (status_vec),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ctrl_wr_o  (ctrl_wr),
        .ctrl_idx_o (ctrl_idx),
        .ctrl_en_o  (ctrl_en),
        .err_clr_o  (err_clr)
    );

    // Enabling a non-existent project is rejected; disabling with any index is harmless
    assign req_bad = ctrl_wr & ctrl_en & ({1'b0, ctrl_idx} >= NUM_PROJ_LIM);
    assign req_ok  = ctrl_wr & ~req_bad;

    // The next switch target: a fresh write beats the pending slot (last wins)
    assign cand_v   = req_ok | pend_q;
    assign cand_idx = req_ok ? ctrl_idx : pend_idx_q;
    assign cand_en  = req_ok ? ctrl_en : pend_en_q;
    assign cand_new = {cand_idx, cand_en} != {cur_idx_q, cur_en_q};

    assign status_vec = pack_status(cur_idx_q, cur_en_q, busy_o, pend_q, err_q);
    assign active_o   = active_q;

    // Next-state, guard countdown, pending slot and outputs of the switch sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_idx_d  = tgt_idx_q;
        tgt_en_d   = tgt_en_q;
        pend_d     = pend_q;
        pend_idx_d = pend_idx_q;
        pend_en_d  = pend_en_q;
        cur_idx_d  = cur_idx_q;
        cur_en_d   = cur_en_q;
        active_d   = active_q;
        busy_o     = 1'b0;
        irq_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cand_v && cand_new) begin
                    tgt_idx_d = cand_idx;
                    tgt_en_d  = cand_en;
                    pend_d    = 1'b0;
                    active_d  = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o  = 1'b1;
                cnt_d   = GUARD_LOAD;
                state_d = S_GUARD;
                if (req_ok) begin
                    pend_d     = 1'b1;
                    pend_idx_d = ctrl_idx;
                    pend_en_d  = ctrl_en;
                end
            end
            S_GUARD: begin
                busy_o = 1'b1;
                if (req_ok) begin
                    pend_d     = 1'b1;
                    pend_idx_d = ctrl_idx;
                    pend_en_d  = ctrl_en;
                end
                if (cnt_q == '0) begin
                    cur_idx_d = tgt_idx_q;
                    cur_en_d  = tgt_en_q;
                    active_d  = tgt_en_q ? (PROJ_ONE << tgt_idx_q) : '0;
                    state_d   = S_APPLY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_APPLY: begin
                irq_o  = 1'b1;
                pend_d = 1'b0;
                if (cand_v && cand_new) begin
                    tgt_idx_d = cand_idx;
                    tgt_en_d  = cand_en;
                    active_d  = '0;
                    state_d   = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers; reset drops every enable line at once
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tgt_idx_q  <= '0;
            tgt_en_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            pend_en_q  <= 1'b0;
            cur_idx_q  <= '0;
            cur_en_q   <= 1'b0;
            active_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_idx_q  <= tgt_idx_d;
            tgt_en_q   <= tgt_en_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            pend_en_q  <= pend_en_d;
            cur_idx_q  <= cur_idx_d;
            cur_en_q   <= cur_en_d;
            active_q   <= active_d;
        end
    end

    // Sticky error flag: a new rejection wins over a simultaneous clear
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (req_bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_active_sequencer.sv
// tb/tb_active_sequencer.sv - randomized and directed bench for active_sequencer
module tb_active_sequencer;

    localparam int NP = 16;
    localparam int G  = 8;

    logic          clk;
    logic          rst_n;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_w;
    logic          ack;
    logic [31:0]   dat_o;
    logic [NP-1:0] active;
    logic          busy, irq;

    int vectors;
    int miscompares;
    int now;

    // reference model: switch schedule expressed as timestamps
    logic          m_ack;
    logic [NP-1:0] m_act;
    logic          m_busy, m_irq, m_err;
    int            m_cidx;
    logic          m_cen;
    logic [7:0]    m_ctrl_idx;
    logic          m_ctrl_en;
    logic          m_infl;
    int            m_apply_at;
    int            m_tidx;
    logic          m_ten;
    logic          m_pend;
    int            m_pidx;
    logic          m_pen;

    active_sequencer #(.NUM_PROJ(NP), .GUARD_CYCLES(G)) dut (
        .wb_clk_i  (clk),
        .rst_n     (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .active_o  (active),
        .busy_o    (busy),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ack = 0; m_act = '0; m_busy = 0; m_irq = 0; m_err = 0;
        m_cidx = 0; m_cen = 0; m_ctrl_idx = '0; m_ctrl_en = 0;
        m_infl = 0; m_apply_at = 0; m_tidx = 0; m_ten = 0;
        m_pend = 0; m_pidx = 0; m_pen = 0;
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(m_cidx & 8'hFF);
        s[8] = m_cen; s[9] = m_busy; s[10] = m_pend; s[11] = m_err;
        return s;
    endfunction

    // advance the model by one cycle from the current inputs, clock the DUT, compare
    task automatic tick();
        logic acc, wr_ctrl, bad, ok, clr, rd_v, cand_v, cen;
        logic [31:0] rd;
        int ridx, cidx;
        acc     = stb && cyc && !m_ack;
        wr_ctrl = acc && we && (adr[3:2] == 2'd0) && (sel == 4'hF);
        ridx    = int'(dat_w[7:0]);
        bad     = wr_ctrl && dat_w[31] && (ridx >= NP);
        ok      = wr_ctrl && !bad;
        clr     = acc && we && (adr[3:2] == 2'd1) && sel[1] && dat_w[11];
        rd_v    = acc && !we;
        rd      = '0;
        if (rd_v) begin
            if (adr[3:2] == 2'd0) rd = {m_ctrl_en, 23'h0, m_ctrl_idx};
            else if (adr[3:2] == 2'd1) rd = model_status();
        end
        if (bad) m_err = 1;
        else if (clr) m_err = 0;
        if (wr_ctrl) begin m_ctrl_idx = dat_w[7:0]; m_ctrl_en = dat_w[31]; end
        if (!m_infl) begin
            if (ok && (ridx != m_cidx || dat_w[31] != m_cen)) begin
                m_infl = 1; m_apply_at = now + 2 + G; m_tidx = ridx; m_ten = dat_w[31];
            end
        end else if (now < m_apply_at) begin
            if (ok) begin m_pend = 1; m_pidx = ridx; m_pen = dat_w[31]; end
        end else begin
            cand_v = ok || m_pend;
            cidx   = ok ? ridx : m_pidx;
            cen    = ok ? dat_w[31] : m_pen;
            m_pend = 0;
            if (cand_v && (cidx != m_cidx || cen != m_cen)) begin
                m_apply_at = now + 2 + G; m_tidx = cidx; m_ten = cen;
            end else begin
                m_infl = 0;
            end
        end
        m_ack = acc;
        now++;
        if (m_infl && now == m_apply_at) begin
            m_cidx = m_tidx; m_cen = m_ten;
            m_act = m_ten ? (NP'(1) << m_tidx) : '0;
            m_irq = 1; m_busy = 0;
        end else if (m_infl) begin
            m_act = '0; m_irq = 0; m_busy = 1;
        end else begin
            m_irq = 0; m_busy = 0;
        end
        @(posedge clk); #1;
        check("ack", 32'(ack), 32'(m_ack));
        check("active", 32'(active), 32'(m_act));
        check("busy", 32'(busy), 32'(m_busy));
        check("irq", 32'(irq), 32'(m_irq));
        check("onehot", 32'($countones(active) <= 1), 32'd1);
        if (rd_v) check("rdata", dat_o, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_op(input logic w, input logic [1:0] r, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdv);
        stb = 1; cyc = 1; we = w; adr = {28'h0, r, 2'b00}; dat_w = d; sel = s;
        tick();
        rdv = dat_o;
        stb = 0; cyc = 0; we = 0; sel = 4'h0;
        tick();
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        bus_op(1'b1, r, d, 4'hF, dummy);
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        bus_op(1'b0, r, 32'h0, 4'hF, v);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 0;
        #1;
        check({tag, "_active"}, 32'(active), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_irq"}, 32'(irq), 32'h0);
        check({tag, "_dat"}, dat_o, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] d;
        int op;
        vectors = 0; miscompares = 0; now = 0;
        rst_n = 0; stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = '0; dat_w = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_active", 32'(active), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_o, 32'h0);
        rst_n = 1;
        idle(2);

        // first switch: project 3, exact latency
        wr(2'd0, 32'h8000_0003);
        idle(7);
        check("p3_last_zero", 32'(active), 32'h0);
        tick();
        check("p3_active", 32'(active), 32'h0008);
        check("p3_irq", 32'(irq), 32'h1);
        idle(3);
        rd(2'd1, v);
        check("p3_status", v, 32'h0000_0103);

        // 3 -> 5 with 7 queued mid-flight
        wr(2'd0, 32'h8000_0005);
        wr(2'd0, 32'h8000_0007);
        rd(2'd1, v);
        check("pend_bit", 32'(v[10]), 32'h1);
        idle(4);
        check("p5_active", 32'(active), 32'h0020);
        tick();
        check("p5_one_cycle", 32'(active), 32'h0);
        idle(8);
        check("p7_guard", 32'(active), 32'h0);
        tick();
        check("p7_active", 32'(active), 32'h0080);
        idle(3);

        // out-of-range enable raises err, W1C clears it
        wr(2'd0, 32'h8000_0010);
        idle(2);
        rd(2'd1, v);
        check("err_set", v, 32'h0000_0907);
        wr(2'd1, 32'h0000_0800);
        rd(2'd1, v);
        check("err_clr", v, 32'h0000_0107);

        // no-op and disable
        wr(2'd0, 32'h8000_0003);
        idle(12);
        wr(2'd0, 32'h8000_0003);
        check("noop_busy", 32'(busy), 32'h0);
        idle(3);
        wr(2'd0, 32'h0000_0000);
        idle(12);
        rd(2'd1, v);
        check("disable_status", v, 32'h0);

        // partial-lane write ignored; held strobe gives alternating acks
        bus_op(1'b1, 2'd0, 32'h8000_0009, 4'h1, v);
        idle(3);
        rd(2'd0, v);
        check("ctrl_after_partial", v, 32'h0);
        stb = 1; cyc = 1; we = 0; adr = 32'h4; sel = 4'hF;
        idle(8);
        stb = 0; cyc = 0;
        tick();

        // reset in the guard interval
        wr(2'd0, 32'h8000_0002);
        idle(12);
        wr(2'd0, 32'h8000_0004);
        tick();
        async_reset("rst_guard");
        rd(2'd1, v);
        check("rst_status", v, 32'h0);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op <= 4) begin
                d[7:0] = 8'($urandom_range(0, 19));
                d[31]  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 5) == 0) begin d[7:0] = 8'(m_cidx); d[31] = m_cen; end
                bus_op(1'b1, 2'd0, d, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF, v);
            end else if (op <= 6) begin
                bus_op(1'b0, 2'($urandom), d, 4'hF, v);
            end else if (op == 7) begin
                bus_op(1'b1, 2'd1, d, 4'($urandom), v);
            end else begin
                bus_op(1'b1, 2'($urandom_range(2, 3)), d, 4'hF, v);
            end
            idle($urandom_range(0, 12));
        end
        async_reset("rst_final");
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
